spi_slave_regs: RTL and testbench

SPI mode-0 responder (slave) for the team's SPI link: the device-side end of the link our SPI master drives.
- Frame: one command/address byte, then one data byte, MSB first, while ss is low.
- Writes land in an internal register bank and are reported to local logic. Reads shift register contents out on miso.
- All SPI pins are sampled in the system clk domain; there is no sck-clocked logic.

---
 rtl/spi_slave_regs_if.sv | 25 ++
 rtl/spi_slave_regs.sv | 149 ++++++++++++++
 tb/tb_spi_slave_regs.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regs_if.sv
// Pin and local-port bundle of the SPI register responder.
interface spi_slave_regs_if;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       done;
  logic [6:0] host_addr;
  logic [7:0] host_rdata;

  modport slave (
    input  ss, sck, mosi, host_addr,
    output miso, miso_oe, wr_valid, wr_addr, wr_data, rd_valid, done, host_rdata
  );

  modport master (
    output ss, sck, mosi, host_addr,
    input  miso, miso_oe, wr_valid, wr_addr, wr_data, rd_valid, done, host_rdata
  );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 register responder, oversampled in the clk domain.
// Frame: command byte {rw, addr[6:0]} then one data byte, MSB first.
module spi_slave_regs #(
  parameter int unsigned NREG   = 16,
  parameter logic [7:0]  DEV_ID = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_regs_if.slave  bus
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] ID_ADDR = 7'h7F;

  typedef enum logic [1:0] {IDLE, CMD, DATA, TAIL} state_t;

  state_t          state_q;
  logic [2:0]      ss_q, sck_q;
  logic [1:0]      mosi_q;
  logic [DW-2:0]   rx_q;
  logic [DW-1:0]   tx_q;
  logic [CW-1:0]   cnt_q;
  logic            rw_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   bank_q [NREG];
  logic            miso_q, miso_oe_q, wr_valid_q, rd_valid_q, done_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  logic            ss_rise, ss_fall, sck_rise, sck_fall, mosi_s;
  logic [AW-1:0]   cmd_addr_c;
  logic [DW-1:0]   cmd_rval_c, rx_byte_c, host_rdata_c;

  // Reset-to-0 synchronisers: ss held low through reset is not seen as a new frame.
  assign ss_rise    =  ss_q[1]  & ~ss_q[2];
  assign ss_fall    = ~ss_q[1]  &  ss_q[2];
  assign sck_rise   =  sck_q[1] & ~sck_q[2];
  assign sck_fall   = ~sck_q[1] &  sck_q[2];
  assign mosi_s     =  mosi_q[1];
  assign cmd_addr_c = {rx_q[DW-3:0], mosi_s};
  assign rx_byte_c  = {rx_q, mosi_s};

  always_comb begin
    cmd_rval_c = '0;
    if (cmd_addr_c < AW'(NREG))  cmd_rval_c = bank_q[IW'(cmd_addr_c)];
    else if (cmd_addr_c == ID_ADDR) cmd_rval_c = DEV_ID;
  end

  always_comb begin
    host_rdata_c = '0;
    if (bus.host_addr < AW'(NREG))  host_rdata_c = bank_q[IW'(bus.host_addr)];
    else if (bus.host_addr == ID_ADDR) host_rdata_c = DEV_ID;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ss_q       <= '0;
      sck_q      <= '0;
      mosi_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) bank_q[i] <= '0;
    end else begin
      ss_q       <= {ss_q[1:0], bus.ss};
      sck_q      <= {sck_q[1:0], bus.sck};
      mosi_q     <= {mosi_q[0], bus.mosi};
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;

      if (ss_rise) begin
        done_q    <= (state_q == TAIL);
        state_q   <= IDLE;
        miso_oe_q <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (ss_fall) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b1;
            state_q   <= CMD;
          end
          CMD: if (sck_rise) begin
            rx_q  <= rx_byte_c[DW-2:0];
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(7)) begin
              rw_q   <= rx_q[DW-2];
              addr_q <= cmd_addr_c;
              if (rx_q[DW-2]) begin
                tx_q       <= cmd_rval_c;
                rd_valid_q <= 1'b1;
              end
              state_q <= DATA;
            end
          end
          DATA: begin
            if (sck_fall && rw_q) begin
              miso_q <= tx_q[DW-1];
              tx_q   <= {tx_q[DW-2:0], 1'b0};
            end
            if (sck_rise) begin
              rx_q <= rx_byte_c[DW-2:0];
              // Counter parks at 15 on the final rise instead of wrapping.
              if (cnt_q == CW'(15)) begin
                state_q <= TAIL;
                if (!rw_q && (addr_q < AW'(NREG))) begin
                  bank_q[IW'(addr_q)] <= rx_byte_c;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= rx_byte_c;
                  wr_valid_q <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          TAIL: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = miso_oe_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.done       = done_q;
  assign bus.host_rdata = host_rdata_c;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: directed frame table, corner sequences, random frames.
module tb_spi_slave_regs;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_slave_regs_if ifc ();
  spi_slave_regs #(.NREG(16), .DEV_ID(8'hA5)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_chk  = 0;
  int n_fail = 0;
  int wr_seen = 0, rd_seen = 0, done_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (ifc.wr_valid) wr_seen++;
      if (ifc.rd_valid) rd_seen++;
      if (ifc.done)     done_seen++;
    end
  end

  // Behavioural model: register array plus last committed write.
  logic [7:0] mbank [16];
  logic [6:0] m_wa;
  logic [7:0] m_wd;

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a < 7'd16)  return mbank[a[3:0]];
    if (a == 7'h7F) return 8'hA5;
    return 8'h00;
  endfunction

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    int         nrise;
    int         exp_wr;
    logic [6:0] exp_wa;
    logic [7:0] exp_wd;
    int         exp_rd;
    logic [7:0] exp_rdata;
    int         exp_done;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_begin();
    ifc.ss = 1'b0;
    clk_n(6);
    chk("miso_oe_active", 32'(ifc.miso_oe), 32'(1));
  endtask

  task automatic send_bit(input logic b, output logic m);
    ifc.mosi = b;
    clk_n(10);
    m = ifc.miso;
    ifc.sck = 1'b1;
    clk_n(10);
    ifc.sck = 1'b0;
  endtask

  task automatic ss_end();
    clk_n(6);
    ifc.ss = 1'b1;
    clk_n(8);
    chk("miso_oe_idle", 32'(ifc.miso_oe), 32'(0));
    chk("miso_idle", 32'(ifc.miso), 32'(0));
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] data, input int nrise,
                           output logic [7:0] mb, output int wr_d, output int rd_d, output int dn_d);
    int w0, r0, d0;
    logic [15:0] bits;
    logic b, m;
    w0 = wr_seen; r0 = rd_seen; d0 = done_seen;
    bits = {cmd, data};
    mb = 8'h00;
    ss_begin();
    for (int i = 0; i < nrise; i++) begin
      b = (i < 16) ? bits[15-i] : 1'($urandom_range(0, 1));
      send_bit(b, m);
      if (i >= 8 && i < 16) mb[15-i] = m;
    end
    ss_end();
    wr_d = wr_seen - w0; rd_d = rd_seen - r0; dn_d = done_seen - d0;
  endtask

  // Applies the architectural rules to the model after a frame.
  task automatic model_update(input logic [7:0] cmd, input logic [7:0] data, input int nrise);
    if (nrise >= 16 && !cmd[7] && cmd[6:0] < 7'd16) begin
      mbank[cmd[3:0]] = data;
      m_wa = cmd[6:0];
      m_wd = data;
    end
  endtask

  task automatic check_host(input logic [6:0] a);
    ifc.host_addr = a;
    clk_n(1);
    chk("host_rdata", 32'(ifc.host_rdata), 32'(m_read(a)));
  endtask

  task automatic check_held();
    chk("wr_addr_held", 32'(ifc.wr_addr), 32'(m_wa));
    chk("wr_data_held", 32'(ifc.wr_data), 32'(m_wd));
  endtask

  initial begin
    vec_t tbl [10];
    logic [7:0] mb;
    int wr_d, rd_d, dn_d;
    logic m;

    tbl[0] = '{8'h05, 8'hAA, 16, 1, 7'h05, 8'hAA, 0, 8'h00, 1};
    tbl[1] = '{8'h85, 8'h00, 16, 0, 7'h00, 8'h00, 1, 8'hAA, 1};
    tbl[2] = '{8'hFF, 8'h00, 16, 0, 7'h00, 8'h00, 1, 8'hA5, 1};
    tbl[3] = '{8'h90, 8'h00, 16, 0, 7'h00, 8'h00, 1, 8'h00, 1};
    tbl[4] = '{8'h7F, 8'h12, 16, 0, 7'h00, 8'h00, 0, 8'h00, 1};
    tbl[5] = '{8'hFF, 8'h00, 16, 0, 7'h00, 8'h00, 1, 8'hA5, 1};
    tbl[6] = '{8'h03, 8'h55, 12, 0, 7'h00, 8'h00, 0, 8'h00, 0};
    tbl[7] = '{8'h83, 8'h00, 16, 0, 7'h00, 8'h00, 1, 8'h00, 1};
    tbl[8] = '{8'h02, 8'h3C, 24, 1, 7'h02, 8'h3C, 0, 8'h00, 1};
    tbl[9] = '{8'h82, 8'h00, 16, 0, 7'h00, 8'h00, 1, 8'h3C, 1};

    for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
    m_wa = 7'h00; m_wd = 8'h00;

    ifc.ss = 1'b1; ifc.sck = 1'b0; ifc.mosi = 1'b0; ifc.host_addr = 7'h00;
    rst = 1'b0;
    clk_n(3);
    chk("rst_miso", 32'(ifc.miso), 32'(0));
    chk("rst_miso_oe", 32'(ifc.miso_oe), 32'(0));
    chk("rst_wr_valid", 32'(ifc.wr_valid), 32'(0));
    chk("rst_rd_valid", 32'(ifc.rd_valid), 32'(0));
    chk("rst_done", 32'(ifc.done), 32'(0));
    chk("rst_wr_addr", 32'(ifc.wr_addr), 32'(0));
    chk("rst_wr_data", 32'(ifc.wr_data), 32'(0));
    chk("rst_host_rdata", 32'(ifc.host_rdata), 32'(0));
    rst = 1'b1;
    clk_n(5);

    for (int v = 0; v < 10; v++) begin
      run_frame(tbl[v].cmd, tbl[v].data, tbl[v].nrise, mb, wr_d, rd_d, dn_d);
      chk($sformatf("vec%0d_wr_cnt", v), 32'(wr_d), 32'(tbl[v].exp_wr));
      chk($sformatf("vec%0d_rd_cnt", v), 32'(rd_d), 32'(tbl[v].exp_rd));
      chk($sformatf("vec%0d_done_cnt", v), 32'(dn_d), 32'(tbl[v].exp_done));
      if (tbl[v].exp_wr != 0) begin
        chk($sformatf("vec%0d_wr_addr", v), 32'(ifc.wr_addr), 32'(tbl[v].exp_wa));
        chk($sformatf("vec%0d_wr_data", v), 32'(ifc.wr_data), 32'(tbl[v].exp_wd));
      end
      if (tbl[v].exp_rd != 0 && tbl[v].nrise >= 16)
        chk($sformatf("vec%0d_miso_byte", v), 32'(mb), 32'(tbl[v].exp_rdata));
      model_update(tbl[v].cmd, tbl[v].data, tbl[v].nrise);
      check_held();
      check_host(tbl[v].cmd[6:0]);
    end

    // Reset in the middle of the data byte, ss kept low across it.
    ifc.host_addr = 7'h05;
    ss_begin();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] bits;
      bits = 16'h0577;
      send_bit(bits[15-i], m);
    end
    rst = 1'b0;
    clk_n(2);
    for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
    m_wa = 7'h00; m_wd = 8'h00;
    chk("midrst_miso_oe", 32'(ifc.miso_oe), 32'(0));
    chk("midrst_wr_addr", 32'(ifc.wr_addr), 32'(0));
    chk("midrst_wr_data", 32'(ifc.wr_data), 32'(0));
    chk("midrst_bank5", 32'(ifc.host_rdata), 32'(0));
    rst = 1'b1;
    clk_n(3);
    begin
      int w0, d0;
      w0 = wr_seen; d0 = done_seen;
      for (int i = 12; i < 16; i++) send_bit(1'b1, m);
      chk("postrst_miso_oe", 32'(ifc.miso_oe), 32'(0));
      ss_end();
      chk("postrst_no_wr", 32'(wr_seen - w0), 32'(0));
      chk("postrst_no_done", 32'(done_seen - d0), 32'(0));
    end
    check_host(7'h05);
    run_frame(8'h09, 8'h5A, 16, mb, wr_d, rd_d, dn_d);
    chk("postrst_frame_wr", 32'(wr_d), 32'(1));
    chk("postrst_frame_done", 32'(dn_d), 32'(1));
    model_update(8'h09, 8'h5A, 16);
    check_held();
    check_host(7'h09);

    // Random frames against the model.
    for (int n = 0; n < 30; n++) begin
      logic [6:0] a;
      logic rw;
      logic [7:0] d, exp_rb;
      int nr, r;
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 3:    a = 7'($urandom_range(0, 15));
        1:       a = 7'h7F;
        default: a = 7'($urandom_range(16, 126));
      endcase
      d = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 6)      nr = 16;
      else if (r < 8) nr = $urandom_range(1, 15);
      else            nr = $urandom_range(17, 24);
      exp_rb = m_read(a);
      run_frame({rw, a}, d, nr, mb, wr_d, rd_d, dn_d);
      chk($sformatf("rnd%0d_wr_cnt", n), 32'(wr_d),
          32'((nr >= 16 && !rw && a < 7'd16) ? 1 : 0));
      chk($sformatf("rnd%0d_rd_cnt", n), 32'(rd_d), 32'((rw && nr >= 8) ? 1 : 0));
      chk($sformatf("rnd%0d_done_cnt", n), 32'(dn_d), 32'((nr >= 16) ? 1 : 0));
      if (rw && nr >= 16) chk($sformatf("rnd%0d_miso_byte", n), 32'(mb), 32'(exp_rb));
      model_update({rw, a}, d, nr);
      check_held();
      check_host(7'($urandom_range(0, 17)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
